dac_wavegen: RTL and testbench
==============================

# dac_wavegen

Parametrised waveform driver for the resistor-ladder DAC outputs. It produces a WIDTH-bit registered code that goes straight to the ladder output pins. The code is either static or steps as a sawtooth or triangle at a programmable sample rate. The top level maps `dac_out[i]` onto pin `bit<i>`; this block replaces the fixed tie-off of the ladder bits with a live, clocked source.

## Interface

Parameters:
- `WIDTH`, 5: DAC code width, equal to the number of ladder bits. MAX = 2^WIDTH−1.
- `DIV_W`, 16: width of the sample-rate divider.

Ports:
- `clk`  in  1: single system clock. All logic is on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `mode`  in  2: 00 STATIC, 01 SAW, 10 TRI, 11 HOLD.
- `code`  in  WIDTH: static level in STATIC mode; preload value for `load`.
- `step`  in  WIDTH: increment or decrement applied per sample in SAW and TRI.
- `div`  in  DIV_W: sample period minus 1, in clk cycles.
- `load`  in  1: single-cycle pulse that preloads the accumulator.
- `dac_out`  out  WIDTH: registered DAC code driving the ladder pins.
- `tick`  out  1: one-cycle pulse marking a new sample on `dac_out`.
- `wrap`  out  1: one-cycle pulse on sawtooth overflow or on reaching the triangle top.

## Operation

State:
- Divider counter `cnt` (DIV_W bits).
- Accumulator `acc`, which is `dac_out` itself.
- Direction flag `dir`, with values UP and DOWN.

Divider:
- Each cycle: if `cnt >= div`, then `cnt`←0 and the sample event fires. Otherwise `cnt`←`cnt`+1.
- `div` = 0 gives a sample event every cycle.
- `div` is compared live. If `div` is lowered below `cnt`, the event fires on the next edge.

Accumulator update, applied in priority order on each edge:
1. `rst`: `acc`=0, `cnt`=0, `dir`=UP, `tick`=0, `wrap`=0.
2. `load`: `acc`←`code`, `dir`←UP, `cnt`←0, `tick`←1, `wrap`←0. A coinciding sample event is discarded.
3. STATIC: `acc`←`code` on every cycle, regardless of the sample event. `tick` still follows the sample event. `wrap`=0.
4. Sample event in SAW:
   - `acc`←(`acc`+`step`) mod 2^WIDTH.
   - `wrap`←1 when the WIDTH+1-bit sum carries out.
5. Sample event in TRI, direction UP:
   - If `acc` > MAX−`step`: `acc`←MAX, `dir`←DOWN, `wrap`←1.
   - Otherwise `acc`←`acc`+`step`.
6. Sample event in TRI, direction DOWN:
   - If `acc` < `step`: `acc`←0, `dir`←UP.
   - Otherwise `acc`←`acc`−`step`.
7. HOLD: `acc` is frozen. The divider runs and `tick` still pulses.

Additional rules:
- `tick`←1 on any sample event in any mode, and on `load`. It is 0 otherwise.
- `wrap`←0 on every edge that does not set it.
- `step` = 0 in SAW or TRI holds `acc`, with no `wrap`.
- A mode change keeps the current `acc` and `dir`. Only `rst` and `load` reset `dir`.
- Comparisons use WIDTH+1-bit unsigned arithmetic, so nothing wraps silently in TRI.

## Timing

- Reset value of every output is 0 (`dac_out`, `tick`, `wrap`), valid on the first edge with `rst` high.
- `dac_out`, `tick` and `wrap` are all registered. No combinational path exists from inputs to outputs.
- `tick` and `wrap` are high in the same cycle the new value first appears on `dac_out`.
- Sample period is `div`+1 cycles. After reset or `load`, the first sample event occurs `div`+1 cycles later.
- STATIC latency: `code` appears on `dac_out` one cycle after it is applied.
- `load` latency: `code` appears on `dac_out` one cycle after the `load` pulse.

## Configuration

- Macro: `DAC_WAVEGEN_TRIANGLE_EN`.
- When defined: TRI mode and the `dir` flag are implemented as described above.
- When undefined: `dir` is not built and `mode`=10 behaves exactly as HOLD.
- All other modes are identical in both builds.

## Test plan

All scenarios use WIDTH=5 (MAX=31).

- Reset: run SAW with `div`=0 and `step`=3, then assert `rst` for 2 cycles mid-run → `dac_out`=0, `tick`=0 and `wrap`=0 on the first `rst` edge; after release, first `tick` after `div`+1 cycles with `dac_out`=3.
- STATIC: `mode`=00, `code`=21, then `code`=9 → `dac_out`=21 one cycle after it is applied and 9 one cycle after the change; `wrap` never asserts.
- SAW: `div`=3, `step`=1, after reset → `tick` every 4 cycles; `dac_out` steps 1, 2, …, 31, 0; `wrap` pulses only with 0.
- SAW preload: `load` with `code`=28, `step`=7 → `dac_out`=28, then 3 with `wrap`=1.
- TRI (macro defined): `div`=0, `step`=4, `load` `code`=24 → sequence 24, 28, 31 (`wrap`=1), 27, 23, …, 3, 0, 4, 8.
- Collision and macro off:
  - `load` (`code`=10) asserted on the same edge as a sample event in SAW → `dac_out`=10, with the next `tick` `div`+1 cycles later.
  - With the macro undefined, `mode`=10 → `dac_out` frozen while `tick` continues.

Source files
------------

// File: rtl/dac_wavegen.sv
// Ladder DAC code source: static, sawtooth, triangle (`DAC_WAVEGEN_TRIANGLE_EN`) or hold; outputs registered, 1-cycle latency.
// No backpressure: samples are produced every div+1 cycles unconditionally.
module dac_wavegen #(
  parameter int WIDTH = 5,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] code,
  input  logic [WIDTH-1:0] step,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  output logic [WIDTH-1:0] dac_out,
  output logic             tick,
  output logic             wrap
);

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
`ifdef DAC_WAVEGEN_TRIANGLE_EN
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [WIDTH:0] MAX_EXT = {1'b0, {WIDTH{1'b1}}};

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  dir_e dir, dir_nxt;
`endif

  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic             sample;
  logic [WIDTH-1:0] acc_nxt;
  logic             tick_nxt;
  logic             wrap_nxt;
  logic [WIDTH:0]   sum;

  // div is compared live, so lowering it below cnt fires on the next edge
  assign sample = (cnt >= div);
  assign sum    = {1'b0, dac_out} + {1'b0, step};

  always_comb begin
    cnt_nxt  = sample ? '0 : cnt + DIV_W'(1);
    acc_nxt  = dac_out;
    tick_nxt = sample;
    wrap_nxt = 1'b0;
`ifdef DAC_WAVEGEN_TRIANGLE_EN
    dir_nxt  = dir;
`endif
    if (load) begin
      // a coinciding sample event is swallowed by the preload
      cnt_nxt  = '0;
      acc_nxt  = code;
      tick_nxt = 1'b1;
`ifdef DAC_WAVEGEN_TRIANGLE_EN
      dir_nxt  = UP;
`endif
    end else begin
      case (mode)
        MODE_STATIC: acc_nxt = code;
        MODE_SAW: begin
          if (sample) begin
            acc_nxt  = sum[WIDTH-1:0];
            wrap_nxt = sum[WIDTH];
          end
        end
`ifdef DAC_WAVEGEN_TRIANGLE_EN
        MODE_TRI: begin
          if (sample) begin
            if (dir == UP) begin
              if ({1'b0, dac_out} > (MAX_EXT - {1'b0, step})) begin
                acc_nxt  = MAX_EXT[WIDTH-1:0];
                dir_nxt  = DOWN;
                wrap_nxt = 1'b1;
              end else begin
                acc_nxt = sum[WIDTH-1:0];
              end
            end else begin
              if ({1'b0, dac_out} < {1'b0, step}) begin
                acc_nxt = '0;
                dir_nxt = UP;
              end else begin
                acc_nxt = dac_out - step;
              end
            end
          end
        end
`endif
        default: acc_nxt = dac_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      dac_out <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
`ifdef DAC_WAVEGEN_TRIANGLE_EN
      dir     <= UP;
`endif
    end else begin
      cnt     <= cnt_nxt;
      dac_out <= acc_nxt;
      tick    <= tick_nxt;
      wrap    <= wrap_nxt;
`ifdef DAC_WAVEGEN_TRIANGLE_EN
      dir     <= dir_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_dac_wavegen.sv
// Directed bench for dac_wavegen (WIDTH=5); TRI scenario selected by DAC_WAVEGEN_TRIANGLE_EN.
module tb_dac_wavegen;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [4:0] code;
  logic [4:0] step;
  logic [15:0] div;
  logic       load;
  logic [4:0] dac_out;
  logic       tick;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  dac_wavegen #(.WIDTH(5), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .code(code), .step(step),
    .div(div), .load(load), .dac_out(dac_out), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int exp_v;
    rst = 1'b1; mode = 2'b01; div = 16'd0; step = 5'd3; code = 5'd0; load = 1'b0;
    cyc();
    total++;
    if (dac_out !== 5'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
      bad++; $display("FAIL reset_init: out=%0d tick=%0b wrap=%0b want 0/0/0", dac_out, tick, wrap);
    end
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      exp_v = 3 * i;
      total++;
      if (dac_out !== exp_v[4:0] || tick !== 1'b1) begin
        bad++; $display("FAIL saw_run%0d: out=%0d tick=%0b want %0d/1", i, dac_out, tick, exp_v);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++;
      if (dac_out !== 5'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
        bad++; $display("FAIL reset_mid%0d: out=%0d tick=%0b wrap=%0b want 0/0/0", i, dac_out, tick, wrap);
      end
    end
    rst = 1'b0;
    cyc();
    total++;
    if (dac_out !== 5'd3 || tick !== 1'b1) begin
      bad++; $display("FAIL reset_release: out=%0d tick=%0b want 3/1", dac_out, tick);
    end
  endtask

  task automatic test_static;
    mode = 2'b00; div = 16'd2; code = 5'd21;
    cyc();
    total++;
    if (dac_out !== 5'd21 || wrap !== 1'b0) begin
      bad++; $display("FAIL static_21: out=%0d wrap=%0b want 21/0", dac_out, wrap);
    end
    code = 5'd9;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (dac_out !== 5'd9 || wrap !== 1'b0) begin
        bad++; $display("FAIL static_9_%0d: out=%0d wrap=%0b want 9/0", i, dac_out, wrap);
      end
    end
  endtask

  task automatic test_saw;
    int exp_v;
    rst = 1'b1; mode = 2'b01; div = 16'd3; step = 5'd1;
    cyc();
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      for (int k = 0; k < 3; k++) begin
        cyc();
        total++;
        if (tick !== 1'b0 || wrap !== 1'b0) begin
          bad++; $display("FAIL saw_gap%0d: tick=%0b wrap=%0b want 0/0", i, tick, wrap);
        end
      end
      cyc();
      exp_v = i % 32;
      total++;
      if (tick !== 1'b1 || dac_out !== exp_v[4:0] || wrap !== (i == 32)) begin
        bad++; $display("FAIL saw_sample%0d: out=%0d tick=%0b wrap=%0b want %0d/1/%0b",
                        i, dac_out, tick, wrap, exp_v, (i == 32));
      end
    end
  endtask

  task automatic test_saw_preload;
    step = 5'd7; code = 5'd28; load = 1'b1;
    cyc();
    load = 1'b0;
    total++;
    if (dac_out !== 5'd28 || tick !== 1'b1 || wrap !== 1'b0) begin
      bad++; $display("FAIL preload: out=%0d tick=%0b wrap=%0b want 28/1/0", dac_out, tick, wrap);
    end
    for (int k = 0; k < 3; k++) cyc();
    total++;
    if (tick !== 1'b0) begin
      bad++; $display("FAIL preload_gap: tick=%0b want 0", tick);
    end
    cyc();
    total++;
    if (dac_out !== 5'd3 || tick !== 1'b1 || wrap !== 1'b1) begin
      bad++; $display("FAIL preload_wrap: out=%0d tick=%0b wrap=%0b want 3/1/1", dac_out, tick, wrap);
    end
  endtask

  task automatic test_collision;
    step = 5'd5; div = 16'd2;
    cyc();
    cyc();
    code = 5'd10; load = 1'b1;
    cyc();
    load = 1'b0;
    total++;
    if (dac_out !== 5'd10 || tick !== 1'b1 || wrap !== 1'b0) begin
      bad++; $display("FAIL collide_load: out=%0d tick=%0b wrap=%0b want 10/1/0", dac_out, tick, wrap);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      total++;
      if (tick !== 1'b0 || dac_out !== 5'd10) begin
        bad++; $display("FAIL collide_gap%0d: out=%0d tick=%0b want 10/0", k, dac_out, tick);
      end
    end
    cyc();
    total++;
    if (dac_out !== 5'd15 || tick !== 1'b1) begin
      bad++; $display("FAIL collide_next: out=%0d tick=%0b want 15/1", dac_out, tick);
    end
  endtask

  task automatic test_div_lower;
    div = 16'd10; code = 5'd0; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    total++;
    if (tick !== 1'b0 || dac_out !== 5'd0) begin
      bad++; $display("FAIL div_lower_gap: out=%0d tick=%0b want 0/0", dac_out, tick);
    end
    div = 16'd2;
    cyc();
    total++;
    if (tick !== 1'b1 || dac_out !== 5'd5) begin
      bad++; $display("FAIL div_lower_fire: out=%0d tick=%0b want 5/1", dac_out, tick);
    end
  endtask

  task automatic test_hold(input logic [1:0] m);
    mode = m; div = 16'd0; code = 5'd13; load = 1'b1;
    cyc();
    load = 1'b0; code = 5'd20;
    for (int k = 0; k < 4; k++) begin
      cyc();
      total++;
      if (dac_out !== 5'd13 || tick !== 1'b1 || wrap !== 1'b0) begin
        bad++; $display("FAIL hold_m%0d_%0d: out=%0d tick=%0b wrap=%0b want 13/1/0", m, k, dac_out, tick, wrap);
      end
    end
  endtask

`ifdef DAC_WAVEGEN_TRIANGLE_EN
  task automatic test_tri;
    int exp_seq [12] = '{28, 31, 27, 23, 19, 15, 11, 7, 3, 0, 4, 8};
    int exp_v;
    mode = 2'b10; div = 16'd0; step = 5'd4; code = 5'd24; load = 1'b1;
    cyc();
    load = 1'b0;
    total++;
    if (dac_out !== 5'd24 || tick !== 1'b1) begin
      bad++; $display("FAIL tri_load: out=%0d tick=%0b want 24/1", dac_out, tick);
    end
    for (int i = 0; i < 12; i++) begin
      cyc();
      exp_v = exp_seq[i];
      total++;
      if (dac_out !== exp_v[4:0] || tick !== 1'b1 || wrap !== (i == 1)) begin
        bad++; $display("FAIL tri_step%0d: out=%0d tick=%0b wrap=%0b want %0d/1/%0b",
                        i, dac_out, tick, wrap, exp_v, (i == 1));
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; mode = 2'b00; code = '0; step = '0; div = '0; load = 1'b0;
    test_reset();
    test_static();
    test_saw();
    test_saw_preload();
    test_collision();
    test_div_lower();
    test_hold(2'b11);
`ifdef DAC_WAVEGEN_TRIANGLE_EN
    test_tri();
`else
    test_hold(2'b10);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
